data_mem_ctrl: RTL and testbench

Parametrised single-port data memory for the 16-bit RISC core's load/store path. Supersedes the plain combinational-read memory with:
- configurable width, depth and read latency;
- per-byte write enables;
- a req/ready/rvalid handshake;
- out-of-range address detection;
- optional per-byte parity checking.

It sits between the core's memory stage and the storage array.

---
 rtl/data_mem_ctrl_if.sv | 26 ++
 rtl/data_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the core memory stage and data_mem_ctrl.
// The core drives the request side (master); the controller answers (slave).
interface data_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory with byte enables, configurable read
// latency, req/ready/rvalid handshake and out-of-range detection.
// Optional feature macro: DATA_MEM_PARITY_EN (per-byte even parity storage/check).
module data_mem_ctrl #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_ctrl_if.slave   bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 2;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    // Range limit widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]    DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              oor_q;
    logic              rvalid_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              ready;
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              acc_wr;
    logic              acc_rd;
    logic              complete;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_oor;
    logic [DATA_W-1:0] rd_word;
    logic              par_err;

    assign bus.ready  = ready;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

    // Decode the incoming request and pick the address of the read being completed.
    always_comb begin
        ready    = (state == IDLE);
        idx      = bus.addr[IDX_W-1:0];
        oor      = ({1'b0, bus.addr} >= DEPTH_A);
        acc_wr   = bus.req && ready && bus.we;
        acc_rd   = bus.req && ready && !bus.we;
        // READ_LAT == 1 completes on the accept edge itself, so it never waits.
        complete = (READ_LAT == 1) ? acc_rd : ((state == RD_WAIT) && (cnt == CNT_ONE));
        rd_idx   = (state == RD_WAIT) ? idx_q : idx;
        rd_oor   = (state == RD_WAIT) ? oor_q : oor;
        rd_word  = mem[rd_idx];
    end

    // Byte-masked array write; out-of-range writes leave the array untouched.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (acc_wr && !oor && bus.be[i]) begin
                mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    // Store one even-parity bit per enabled byte alongside the data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (acc_wr && !oor && bus.be[i]) begin
                par_mem[idx][i] <= ^bus.wdata[8*i +: 8];
            end
        end
    end

    // A byte plus its parity bit must hold an even number of ones.
    always_comb begin
        par_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (^{rd_word[8*i +: 8], par_mem[rd_idx][i]}) begin
                par_err = 1'b1;
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // Handshake FSM, latency counter and registered read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= complete;
            err_q    <= (acc_wr && oor) || (complete && (rd_oor || par_err));
            if (complete) begin
                rdata_q <= rd_oor ? '0 : rd_word;
            end
            case (state)
                IDLE: begin
                    if (acc_rd && (READ_LAT > 1)) begin
                        state <= RD_WAIT;
                        cnt   <= CNT_LOAD;
                        idx_q <= idx;
                        oor_q <= oor;
                    end
                end
                RD_WAIT: begin
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with READ_LAT = 1 and one
// with READ_LAT = 3, sharing clock and reset.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   seen;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) b1 ();
    data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) b3 ();

    data_mem_ctrl #(.DATA_W(16), .DEPTH(32), .ADDR_W(16), .READ_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    data_mem_ctrl #(.DATA_W(16), .DEPTH(32), .ADDR_W(16), .READ_LAT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] e);
        b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d; b1.be = e;
    endtask

    task automatic drv3(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] e);
        b3.req = r; b3.we = w; b3.addr = a; b3.wdata = d; b3.be = e;
    endtask

    initial begin
        rst_n = 1'b0;
        drv1(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        drv3(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        tick();
        chk("rst_ready1",  {31'b0, b1.ready},  32'd1);
        chk("rst_rvalid1", {31'b0, b1.rvalid}, 32'd0);
        chk("rst_rdata1",  {16'b0, b1.rdata},  32'd0);
        chk("rst_err1",    {31'b0, b1.err},    32'd0);
        chk("rst_ready3",  {31'b0, b3.ready},  32'd1);
        rst_n = 1'b1;
        tick();

        // Byte-enable merge on the READ_LAT = 1 instance.
        drv1(1'b1, 1'b1, 16'd5, 16'hABCD, 2'b11); tick();
        chk("wr_ready", {31'b0, b1.ready}, 32'd1);
        chk("wr_err",   {31'b0, b1.err},   32'd0);
        drv1(1'b1, 1'b1, 16'd5, 16'h0012, 2'b01); tick();
        drv1(1'b1, 1'b0, 16'd5, 16'h0000, 2'b00); tick();
        chk("be_rvalid", {31'b0, b1.rvalid}, 32'd1);
        chk("be_rdata",  {16'b0, b1.rdata},  32'hAB12);
        chk("be_err",    {31'b0, b1.err},    32'd0);

        // Out-of-range write and read.
        drv1(1'b1, 1'b1, 16'd0, 16'h1111, 2'b11); tick();
        drv1(1'b1, 1'b1, 16'd32, 16'h5555, 2'b11); tick();
        chk("oor_wr_err", {31'b0, b1.err}, 32'd1);
        drv1(1'b0, 1'b0, 16'd0, 16'h0, 2'b00); tick();
        chk("oor_wr_err_pulse", {31'b0, b1.err}, 32'd0);
        drv1(1'b1, 1'b0, 16'd0, 16'h0, 2'b00); tick();
        chk("oor_addr0_kept", {16'b0, b1.rdata}, 32'h1111);
        drv1(1'b1, 1'b0, 16'd40, 16'h0, 2'b00); tick();
        chk("oor_rd_rvalid", {31'b0, b1.rvalid}, 32'd1);
        chk("oor_rd_rdata",  {16'b0, b1.rdata},  32'd0);
        chk("oor_rd_err",    {31'b0, b1.err},    32'd1);
        // Upper address bits alias to index 5 but must still flag out-of-range.
        drv1(1'b1, 1'b0, 16'h8005, 16'h0, 2'b00); tick();
        chk("oor_hi_err", {31'b0, b1.err}, 32'd1);

        // Write then read same address in the next cycle.
        drv1(1'b1, 1'b1, 16'd9, 16'hBEEF, 2'b11); tick();
        drv1(1'b1, 1'b0, 16'd9, 16'h0, 2'b00); tick();
        chk("wr_rd_fwd", {16'b0, b1.rdata}, 32'hBEEF);

        // READ_LAT = 1 streaming.
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, 1'b1, 16'(i), 16'hA000 + 16'(i), 2'b11); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, 1'b0, 16'(i), 16'h0, 2'b00); tick();
            chk($sformatf("stream_ready%0d", i),  {31'b0, b1.ready},  32'd1);
            chk($sformatf("stream_rvalid%0d", i), {31'b0, b1.rvalid}, 32'd1);
            chk($sformatf("stream_rdata%0d", i),  {16'b0, b1.rdata},  32'hA000 + i);
        end
        drv1(1'b0, 1'b0, 16'd0, 16'h0, 2'b00); tick();
        chk("stream_end_rvalid", {31'b0, b1.rvalid}, 32'd0);

        // READ_LAT = 3 latency and ready profile; req held while ready = 0.
        drv3(1'b1, 1'b1, 16'd7, 16'h7777, 2'b11); tick();
        drv3(1'b1, 1'b1, 16'd8, 16'h8888, 2'b11); tick();
        drv3(1'b1, 1'b0, 16'd7, 16'h0, 2'b00); tick();   // accept edge, now cycle 1
        drv3(1'b1, 1'b0, 16'd8, 16'h0, 2'b00);
        chk("lat_c1_ready",  {31'b0, b3.ready},  32'd0);
        chk("lat_c1_rvalid", {31'b0, b3.rvalid}, 32'd0);
        tick();
        chk("lat_c2_ready",  {31'b0, b3.ready},  32'd0);
        chk("lat_c2_rvalid", {31'b0, b3.rvalid}, 32'd0);
        tick();
        chk("lat_c3_ready",  {31'b0, b3.ready},  32'd1);
        chk("lat_c3_rvalid", {31'b0, b3.rvalid}, 32'd1);
        chk("lat_c3_rdata",  {16'b0, b3.rdata},  32'h7777);
        tick();
        chk("lat_c4_ready",  {31'b0, b3.ready},  32'd0);
        chk("lat_c4_rvalid", {31'b0, b3.rvalid}, 32'd0);
        tick();
        chk("lat_c5_rvalid", {31'b0, b3.rvalid}, 32'd0);
        tick();
        chk("lat_c6_rvalid", {31'b0, b3.rvalid}, 32'd1);
        chk("lat_c6_rdata",  {16'b0, b3.rdata},  32'h8888);
        drv3(1'b0, 1'b0, 16'd0, 16'h0, 2'b00);

        // Reset in the middle of a READ_LAT = 3 read.
        drv3(1'b1, 1'b1, 16'd2, 16'h2222, 2'b11); tick();
        drv3(1'b1, 1'b0, 16'd2, 16'h0, 2'b00); tick();
        drv3(1'b0, 1'b0, 16'd0, 16'h0, 2'b00); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready",  {31'b0, b3.ready},  32'd1);
        chk("midrst_rvalid", {31'b0, b3.rvalid}, 32'd0);
        chk("midrst_rdata",  {16'b0, b3.rdata},  32'd0);
        chk("midrst_err",    {31'b0, b3.err},    32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b3.rvalid) seen++;
        end
        chk("midrst_no_rvalid", 32'(seen), 32'd0);

        // Parity check on the READ_LAT = 1 instance.
        drv1(1'b1, 1'b1, 16'd3, 16'h1234, 2'b11); tick();
`ifdef DATA_MEM_PARITY_EN
        dut1.par_mem[3][0] = ~dut1.par_mem[3][0];
`endif
        drv1(1'b1, 1'b0, 16'd3, 16'h0, 2'b00); tick();
        chk("par_rdata", {16'b0, b1.rdata}, 32'h1234);
`ifdef DATA_MEM_PARITY_EN
        chk("par_err", {31'b0, b1.err}, 32'd1);
`else
        chk("par_err", {31'b0, b1.err}, 32'd0);
`endif
        drv1(1'b0, 1'b0, 16'd0, 16'h0, 2'b00); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
